dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates single-port data memory (16-bit address/data) between the CPU datapath and a DMA/loader requester. Sits between the datapath's memory access signals and the Data_Memory instance. Sequences each access through a fixed 3-state transaction and generates the CPU stall. CPU has fixed priority; a starvation counter guarantees DMA progress.

Parameters:
ADDR_W, 16, address width of both requesters and memory
DATA_W, 16, data width
MAX_WAIT, 4, DMA waiting cycles (lost arbitrations) before DMA wins over a pending CPU request; range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU byte address (ALU result)
cpu_wdata  in  DATA_W  CPU store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack = 1 for a read
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational from registered ack)
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same rules as CPU
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DATA_W  read data, valid while dma_ack = 1 for a read
mem_addr  out  ADDR_W  to Data_Memory mem_access_addr
mem_wdata  out  DATA_W  to Data_Memory mem_write_data
mem_we  out  1  to Data_Memory mem_write_en
mem_re  out  1  to Data_Memory mem_read
mem_rdata  in  DATA_W  from Data_Memory (combinational read)

Behaviour:
- Reset (synchronous): state IDLE; mem_we = mem_re = 0; mem_addr = mem_wdata = 0; cpu_ack = dma_ack = 0; cpu_rdata = dma_rdata = 0; wait counter = 0; owner = CPU. Reset mid-transaction aborts it: no ack, no write issued after the reset edge.
- All outputs are registered except cpu_stall.
- States: IDLE -> ACC -> RESP -> IDLE. One transaction takes exactly 3 cycles; max throughput 1 access per 3 cycles.
- IDLE, at clock edge:
  - If only cpu_req: grant CPU.
  - If only dma_req: grant DMA.
  - If both: grant DMA when wait_cnt >= MAX_WAIT, else grant CPU.
  - Grant latches the winner's we/addr/wdata into mem_*; asserts mem_we = we or mem_re = ~we; records owner; moves to ACC.
  - If neither: stay in IDLE.
- ACC (1 cycle): mem_* stable; mem_we high for exactly this cycle (one write per transaction). At the edge leaving ACC:
  - capture mem_rdata into owner's *_rdata (reads only; writes leave *_rdata unchanged);
  - set owner's *_ack = 1; clear mem_we, mem_re; move to RESP.
- RESP (1 cycle): owner's ack high. The requester may keep req high for a new access; the arbiter does not sample requests in RESP. Clear ack; go to IDLE.
- Requests are only sampled in IDLE.
- Dropping req during ACC/RESP does not cancel: the access completes and ack still pulses.
- wait_cnt (4 bits):
  - +1 at each IDLE edge where dma_req = 1 and CPU is granted;
  - saturates at MAX_WAIT;
  - cleared on DMA grant, and on any edge where dma_req = 0.
- Non-owner ack stays 0 throughout a transaction.
- cpu_stall is high from cpu_req assertion through the cycle before cpu_ack, and low in the ack cycle.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACC, RESP};
  - owner enum {OWN_CPU, OWN_DMA};
  - default widths ADDR_W/DATA_W = 16;
  - WAIT_CNT_W = 4.
- One natural sub-module: arb_age_counter, a saturating increment/clear counter with parameter MAX and output 'expired'.

Test Plan:
1. CPU write addr 0x0010 data 0xBEEF, no DMA -> mem_we high exactly 1 cycle (ACC) with mem_addr 0x0010; cpu_ack 2 cycles after req sampled; cpu_stall high for 2 cycles, then low.
2. CPU read of 0x0010 after test 1 -> mem_re 1 cycle; cpu_rdata = 0xBEEF with cpu_ack; dma_ack stays 0.
3. Both req in same IDLE cycle, wait_cnt 0 -> CPU granted; DMA served in the next transaction (ack at cycle 5 relative to first grant).
4. CPU re-requests every IDLE, DMA held, MAX_WAIT = 4 -> 4 CPU transactions, then DMA granted; wait_cnt returns to 0.
5. rst asserted during ACC of a DMA write -> next cycle state IDLE, mem_we = 0, no dma_ack, wait_cnt = 0.
6. dma_req dropped after 2 lost arbitrations, then reasserted -> counter restarts from 0; DMA needs 4 further losses before winning.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU datapath and the DMA/loader.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } arb_owner_e;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter: counts lost arbitrations and flags when the waiter must win.
module arb_age_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_expired
);

  localparam logic [WAIT_CNT_W-1:0] LP_MAX = WAIT_CNT_W'(MAX);

  logic [WAIT_CNT_W-1:0] r_count;
  logic [WAIT_CNT_W-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (i_clr) begin
      w_count_d = '0;
    end else if (i_inc && (r_count < LP_MAX)) begin
      w_count_d = r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_expired = (r_count >= LP_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority, an age counter guarantees DMA progress.
// Every access runs IDLE -> ACC -> RESP; only cpu_stall is combinational.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_e        r_state,     w_state_d;
  arb_owner_e        r_owner,     w_owner_d;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_d;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_d;
  logic              r_mem_we,    w_mem_we_d;
  logic              r_mem_re,    w_mem_re_d;
  logic              r_cpu_ack,   w_cpu_ack_d;
  logic              r_dma_ack,   w_dma_ack_d;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_d;
  logic [DATA_W-1:0] r_dma_rdata, w_dma_rdata_d;

  logic w_grant_cpu;
  logic w_grant_dma;
  logic w_expired;

  // DMA loses an arbitration only when it was pending and the CPU took the slot.
  arb_age_counter #(
    .MAX (MAX_WAIT)
  ) u_age (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (w_grant_cpu & i_dma_req),
    .i_clr     (w_grant_dma | ~i_dma_req),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_mem_we_d    = r_mem_we;
    w_mem_re_d    = r_mem_re;
    w_cpu_ack_d   = r_cpu_ack;
    w_dma_ack_d   = r_dma_ack;
    w_cpu_rdata_d = r_cpu_rdata;
    w_dma_rdata_d = r_dma_rdata;
    w_grant_cpu   = 1'b0;
    w_grant_dma   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_grant_dma = i_dma_req & (~i_cpu_req | w_expired);
        w_grant_cpu = i_cpu_req & ~w_grant_dma;
        if (w_grant_dma) begin
          w_owner_d     = OWN_DMA;
          w_mem_addr_d  = i_dma_addr;
          w_mem_wdata_d = i_dma_wdata;
          w_mem_we_d    = i_dma_we;
          w_mem_re_d    = ~i_dma_we;
          w_state_d     = ACC;
        end else if (w_grant_cpu) begin
          w_owner_d     = OWN_CPU;
          w_mem_addr_d  = i_cpu_addr;
          w_mem_wdata_d = i_cpu_wdata;
          w_mem_we_d    = i_cpu_we;
          w_mem_re_d    = ~i_cpu_we;
          w_state_d     = ACC;
        end
      end
      ACC: begin
        if (r_owner == OWN_CPU) begin
          w_cpu_ack_d = 1'b1;
          if (r_mem_re) w_cpu_rdata_d = i_mem_rdata;
        end else begin
          w_dma_ack_d = 1'b1;
          if (r_mem_re) w_dma_rdata_d = i_mem_rdata;
        end
        w_mem_we_d = 1'b0;
        w_mem_re_d = 1'b0;
        w_state_d  = RESP;
      end
      RESP: begin
        w_cpu_ack_d = 1'b0;
        w_dma_ack_d = 1'b0;
        w_state_d   = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_re    <= w_mem_re_d;
      r_cpu_ack   <= w_cpu_ack_d;
      r_dma_ack   <= w_dma_ack_d;
      r_cpu_rdata <= w_cpu_rdata_d;
      r_dma_rdata <= w_dma_rdata_d;
    end
  end

  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;
  assign o_dma_ack   = r_dma_ack;
  assign o_dma_rdata = r_dma_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios pinned by literals, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_we, mem_re;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_stall (cpu_stall),
    .i_dma_req   (dma_req),
    .i_dma_we    (dma_we),
    .i_dma_addr  (dma_addr),
    .i_dma_wdata (dma_wdata),
    .o_dma_ack   (dma_ack),
    .o_dma_rdata (dma_rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .i_mem_rdata (mem_rdata)
  );

  // Environment memory (Data_Memory stand-in): combinational read, write on a non-reset edge.
  logic [15:0] env_mem [0:255];
  assign mem_rdata = env_mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we && !rst) env_mem[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction occupies the memory for three cycles (grant, access, response).
  int          m_phase;
  int          m_wait;
  bit          m_own_dma;
  logic [15:0] m_mem_addr, m_mem_wdata, m_cpu_rdata, m_dma_rdata;
  logic        m_mem_we, m_mem_re, m_cpu_ack, m_dma_ack;
  logic [15:0] shadow [0:255];

  always @(posedge clk) begin : model
    bit g_cpu, g_dma;
    if (rst) begin
      m_phase = 0; m_wait = 0; m_own_dma = 1'b0;
      m_mem_addr = '0; m_mem_wdata = '0; m_mem_we = 1'b0; m_mem_re = 1'b0;
      m_cpu_ack = 1'b0; m_dma_ack = 1'b0; m_cpu_rdata = '0; m_dma_rdata = '0;
    end else begin
      if (m_phase == 0) begin
        g_dma = dma_req && (!cpu_req || m_wait >= MAX_WAIT);
        g_cpu = cpu_req && !g_dma;
        if (g_dma || g_cpu) begin
          m_own_dma   = g_dma;
          m_mem_addr  = g_dma ? dma_addr : cpu_addr;
          m_mem_wdata = g_dma ? dma_wdata : cpu_wdata;
          m_mem_we    = g_dma ? dma_we : cpu_we;
          m_mem_re    = !m_mem_we;
          m_phase     = 1;
        end
        if (g_dma) m_wait = 0;
        else if (g_cpu && dma_req && m_wait < MAX_WAIT) m_wait = m_wait + 1;
      end else if (m_phase == 1) begin
        if (m_mem_we) shadow[m_mem_addr[7:0]] = m_mem_wdata;
        else if (m_own_dma) m_dma_rdata = shadow[m_mem_addr[7:0]];
        else m_cpu_rdata = shadow[m_mem_addr[7:0]];
        if (m_own_dma) m_dma_ack = 1'b1;
        else m_cpu_ack = 1'b1;
        m_mem_we = 1'b0;
        m_mem_re = 1'b0;
        m_phase  = 2;
      end else begin
        m_cpu_ack = 1'b0;
        m_dma_ack = 1'b0;
        m_phase   = 0;
      end
      if (!dma_req) m_wait = 0;
    end
  end

  int cpu_pend = 0;
  int dma_pend = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mem_addr",  32'(mem_addr),  32'(m_mem_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_mem_wdata));
      check("mem_we",    32'(mem_we),    32'(m_mem_we));
      check("mem_re",    32'(mem_re),    32'(m_mem_re));
      check("cpu_ack",   32'(cpu_ack),   32'(m_cpu_ack));
      check("dma_ack",   32'(dma_ack),   32'(m_dma_ack));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
      check("dma_rdata", 32'(dma_rdata), 32'(m_dma_rdata));
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~m_cpu_ack));
      // Bounded progress: neither requester may wait indefinitely.
      cpu_pend = (rst || !cpu_req || cpu_ack) ? 0 : cpu_pend + 1;
      dma_pend = (rst || !dma_req || dma_ack) ? 0 : dma_pend + 1;
      if (cpu_pend == 30) begin
        n_cmp++; n_err++;
        $display("FAIL cpu_progress: got no ack after %0d cycles expected ack", cpu_pend);
      end
      if (dma_pend == 30) begin
        n_cmp++; n_err++;
        $display("FAIL dma_progress: got no ack after %0d cycles expected ack", dma_pend);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic new_cpu();
    cpu_req   = 1'b1;
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 16'($urandom_range(0, 15));
    cpu_wdata = 16'($urandom);
  endtask

  task automatic new_dma();
    dma_req   = 1'b1;
    dma_we    = 1'($urandom_range(0, 1));
    dma_addr  = 16'($urandom_range(0, 15));
    dma_wdata = 16'($urandom);
  endtask

  // Runs until dma_ack, returning how many CPU acks came first.
  task automatic count_until_dma(output int n_cpu, output bit seen);
    n_cpu = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (cpu_ack) n_cpu++;
      if (dma_ack) seen = 1'b1;
    end
  endtask

  initial begin
    int  n_cpu;
    bit  seen;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      shadow[i]  = '0;
    end
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    step();
    step();
    cmp_en = 1'b1;
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_re",    32'(mem_re),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    rst = 1'b0;

    // CPU write, no DMA.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    #1 check("t1_stall_req", 32'(cpu_stall), 32'd1);
    step();
    check("t1_acc_we",    32'(mem_we),    32'd1);
    check("t1_acc_addr",  32'(mem_addr),  32'h10);
    check("t1_acc_stall", 32'(cpu_stall), 32'd1);
    step();
    check("t1_resp_we",    32'(mem_we),    32'd0);
    check("t1_resp_ack",   32'(cpu_ack),   32'd1);
    check("t1_resp_stall", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    step();
    check("t1_ack_pulse", 32'(cpu_ack), 32'd0);

    // CPU read back.
    cpu_req = 1'b1; cpu_we = 1'b0;
    step();
    check("t2_acc_re", 32'(mem_re), 32'd1);
    step();
    check("t2_ack",     32'(cpu_ack),   32'd1);
    check("t2_rdata",   32'(cpu_rdata), 32'hBEEF);
    check("t2_dma_ack", 32'(dma_ack),   32'd0);
    cpu_req = 1'b0;
    step();

    // Simultaneous requests with a fresh age: CPU first, DMA ack five edges after the grant.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1111;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
    step();
    check("t3_cpu_first", 32'(mem_addr), 32'h20);
    step();
    check("t3_cpu_ack", 32'(cpu_ack), 32'd1);
    check("t3_dma_wait", 32'(dma_ack), 32'd0);
    cpu_req = 1'b0;
    step();
    step();
    check("t3_dma_addr", 32'(mem_addr), 32'h10);
    check("t3_dma_re",   32'(mem_re),   32'd1);
    step();
    check("t3_dma_ack",   32'(dma_ack),   32'd1);
    check("t3_dma_rdata", 32'(dma_rdata), 32'hBEEF);
    dma_req = 1'b0;
    step();

    // CPU hogging: DMA wins after MAX_WAIT lost arbitrations.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h4444;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
    count_until_dma(n_cpu, seen);
    check("t4_cpu_wins", 32'(n_cpu), 32'd4);
    check("t4_dma_seen", 32'(seen), 32'd1);
    check("t4_dma_rdata", 32'(dma_rdata), 32'h1111);
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
    step();

    // DMA drops after two losses: the age restarts from zero.
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 6; i++) step();
    dma_req = 1'b0;
    step();
    dma_req = 1'b1;
    step();
    step();
    count_until_dma(n_cpu, seen);
    check("t6_cpu_wins", 32'(n_cpu), 32'd4);
    check("t6_dma_seen", 32'(seen), 32'd1);
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
    step();

    // Reset during the access cycle of a DMA write aborts it.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0030; dma_wdata = 16'hAAAA;
    step();
    check("t5_acc_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    step();
    check("t5_we_clr",  32'(mem_we),   32'd0);
    check("t5_no_ack",  32'(dma_ack),  32'd0);
    check("t5_addr_clr", 32'(mem_addr), 32'd0);
    rst = 1'b0; dma_req = 1'b0;
    step();
    check("t5_no_ack2", 32'(dma_ack), 32'd0);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (cpu_req && cpu_ack) begin
        if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
        else new_cpu();
      end else if (!cpu_req && $urandom_range(0, 2) == 0) new_cpu();
      else if (cpu_req && $urandom_range(0, 99) == 0) cpu_req = 1'b0;
      if (dma_req && dma_ack) begin
        if ($urandom_range(0, 1) == 0) dma_req = 1'b0;
        else new_dma();
      end else if (!dma_req && $urandom_range(0, 2) == 0) new_dma();
      else if (dma_req && $urandom_range(0, 99) == 0) dma_req = 1'b0;
    end
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    for (int i = 0; i < 5; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
